scan_hex: RTL and testbench

- Parametrised ASCII token scanner for the serial debug unit.
- Sits between the UART receive byte stream and the command/debug controller.
- On request it returns either one raw byte, or one hexadecimal number of up to DATA_W bits parsed from ASCII digits.
- Handles leading-space skipping, terminators, error classification and line drain, which the previous generation scanner lacked.

---
 rtl/scan_hex_pkg.sv | 32 +++
 rtl/scan_hex_if.sv | 33 +++
 rtl/scan_hex_hex_ascii_dec.sv | 28 ++
 rtl/scan_hex.sv | 154 +++++++++++++++
 tb/tb_scan_hex.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/scan_hex_pkg.sv
// Shared definitions for the ASCII token scanner: state codes, ASCII constants, error codes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package scan_hex_pkg;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_BYTE  = 3'd1;
   localparam logic [2:0] ST_SKIP  = 3'd2;
   localparam logic [2:0] ST_DIGIT = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // ASCII characters with special meaning to the scanner
   localparam logic [7:0] SP = 8'h20;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   // Error classification reported with each token
   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_EMPTY = 2'd1,
      ERR_BADCH = 2'd2,
      ERR_OVF   = 2'd3
   } err_t;

   // End of line: the only characters that end a drain
   function automatic logic is_eol(input logic [7:0] ch);
      return (ch == CR) || (ch == LF);
   endfunction

endpackage

// File: rtl/scan_hex_if.sv
// Byte stream and token request/result bundle between UART receiver, scanner and controller.
// Latency: none (wiring only).
// Backpressure: rdy_rx from the scanner gates byte consumption.
interface scan_hex_if #(
   parameter int DATA_W = 32
);
   localparam int MAX_DIGITS = DATA_W / 4;
   localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

   logic [7:0]        d_rx;
   logic              vld_rx;
   logic              rdy_rx;
   logic              req_rx;
   logic              type_rx;
   logic              ack_rx;
   logic              flag_rx;
   logic [1:0]        err_rx;
   logic [DATA_W-1:0] din_rx;
   logic [CNT_W-1:0]  ndig;

   // Scanner side
   modport slave (
      input  d_rx, vld_rx, req_rx, type_rx,
      output rdy_rx, ack_rx, flag_rx, err_rx, din_rx, ndig
   );

   // Byte source / controller side
   modport master (
      output d_rx, vld_rx, req_rx, type_rx,
      input  rdy_rx, ack_rx, flag_rx, err_rx, din_rx, ndig
   );

endinterface

// File: rtl/scan_hex_hex_ascii_dec.sv
// Classifies one ASCII character: hex digit value, hex-digit flag, token terminator flag.
// Latency: combinational.
// Backpressure: none.
module hex_ascii_dec
   import scan_hex_pkg::*;
(
   input  logic [7:0] ch,
   output logic [3:0] nib,
   output logic       is_hex,
   output logic       is_term
);

   // Digit value: '0'-'9' map directly, 'A'-'F'/'a'-'f' are low nibble + 9
   always_comb begin
      nib    = 4'd0;
      is_hex = 1'b0;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         is_hex = 1'b1;
         nib    = ch[3:0];
      end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
         is_hex = 1'b1;
         nib    = ch[3:0] + 4'd9;
      end
   end

   assign is_term = (ch == SP) || (ch == CR) || (ch == LF);

endmodule

// File: rtl/scan_hex.sv
// ASCII token scanner: returns one raw byte or one hex number (up to DATA_W bits) per request.
// Latency: ack_rx one cycle after the terminating byte is consumed.
// Backpressure: rdy_rx high only in BYTE/SKIP/DIGIT/DRAIN; bytes otherwise left untouched upstream.
module scan_hex
   import scan_hex_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic      clk,
   input  logic      rst,
   scan_hex_if.slave bus
);

   localparam int MAX_DIGITS = DATA_W / 4;
   localparam int CNT_W      = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

   logic [2:0]        state_q, state_nxt;
   logic              mode_q, mode_nxt;
   logic [DATA_W-1:0] din_q, din_nxt;
   logic [CNT_W-1:0]  ndig_q, ndig_nxt;
   err_t              err_q, err_nxt;
   logic              flag_q, flag_nxt;

   logic [3:0]        nib;
   logic              is_hex;
   logic              is_term;
   logic              rdy;
   logic              take;

   hex_ascii_dec u_dec (
      .ch      (bus.d_rx),
      .nib     (nib),
      .is_hex  (is_hex),
      .is_term (is_term)
   );

   assign rdy  = (state_q == ST_BYTE) || (state_q == ST_SKIP) ||
                 (state_q == ST_DIGIT) || (state_q == ST_DRAIN);
   assign take = bus.vld_rx && rdy;

   // Next-state and result-register computation for the token FSM
   always_comb begin
      state_nxt = state_q;
      mode_nxt  = mode_q;
      din_nxt   = din_q;
      ndig_nxt  = ndig_q;
      err_nxt   = err_q;
      flag_nxt  = flag_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_rx) begin
               mode_nxt  = bus.type_rx;
               din_nxt   = '0;
               ndig_nxt  = '0;
               err_nxt   = ERR_NONE;
               flag_nxt  = 1'b0;
               state_nxt = bus.type_rx ? ST_SKIP : ST_BYTE;
            end
         end

         // Both are "waiting for the first byte"; the latched mode picks the rule
         ST_BYTE, ST_SKIP: begin
            if (take) begin
               if (!mode_q) begin
                  din_nxt   = DATA_W'(bus.d_rx);
                  ndig_nxt  = '0;
                  state_nxt = ST_DONE;
               end else if (bus.d_rx == SP) begin
                  state_nxt = ST_SKIP;
               end else if (is_eol(bus.d_rx)) begin
                  err_nxt   = ERR_EMPTY;
                  state_nxt = ST_DONE;
               end else if (is_hex) begin
                  din_nxt   = DATA_W'(nib);
                  ndig_nxt  = CNT_W'(1);
                  state_nxt = ST_DIGIT;
               end else begin
                  err_nxt   = ERR_BADCH;
                  state_nxt = ST_DRAIN;
               end
            end
         end

         ST_DIGIT: begin
            if (take) begin
               if (is_hex) begin
                  if (ndig_q == MAX_CNT) begin
                     // Keep the first MAX_DIGITS digits; discard the rest of the line
                     err_nxt   = ERR_OVF;
                     state_nxt = ST_DRAIN;
                  end else begin
                     din_nxt  = {din_q[DATA_W-5:0], nib};
                     ndig_nxt = ndig_q + CNT_W'(1);
                  end
               end else if (is_term) begin
                  state_nxt = ST_DONE;
               end else begin
                  err_nxt   = ERR_BADCH;
                  state_nxt = ST_DRAIN;
               end
            end
         end

         // Resynchronise on end of line after any error
         ST_DRAIN: begin
            if (take && is_eol(bus.d_rx)) begin
               state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Flag becomes valid together with ack, on entry to DONE
      if (state_nxt == ST_DONE && state_q != ST_DONE) begin
         flag_nxt = (err_nxt != ERR_NONE);
      end
   end

   // State and result registers, cleared asynchronously at any point in a token
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         din_q   <= '0;
         ndig_q  <= '0;
         err_q   <= ERR_NONE;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         mode_q  <= mode_nxt;
         din_q   <= din_nxt;
         ndig_q  <= ndig_nxt;
         err_q   <= err_nxt;
         flag_q  <= flag_nxt;
      end
   end

   assign bus.rdy_rx  = rdy;
   assign bus.ack_rx  = (state_q == ST_DONE);
   assign bus.flag_rx = flag_q;
   assign bus.err_rx  = err_q;
   assign bus.din_rx  = din_q;
   assign bus.ndig    = ndig_q;

endmodule

// File: tb/tb_scan_hex.sv
// Directed bench for scan_hex: a 32-bit and a 16-bit scanner share one byte source.
// Latency: ack checked exactly one cycle after the terminating byte is consumed.
// Backpressure: bytes are held on vld until rdy is seen, with a bounded wait.
module tb_scan_hex;

   logic        clk;
   logic        rst;
   logic [7:0]  d;
   logic        vld;
   logic        req;
   logic        typ;
   logic        sel;   // 0 = 32-bit scanner, 1 = 16-bit scanner

   int total;
   int bad;

   scan_hex_if #(.DATA_W(32)) b32 ();
   scan_hex_if #(.DATA_W(16)) b16 ();

   assign b32.d_rx    = d;
   assign b32.vld_rx  = vld;
   assign b32.req_rx  = req && !sel;
   assign b32.type_rx = typ;
   assign b16.d_rx    = d;
   assign b16.vld_rx  = vld;
   assign b16.req_rx  = req && sel;
   assign b16.type_rx = typ;

   scan_hex #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   scan_hex #(.DATA_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   wire        rdy  = sel ? b16.rdy_rx  : b32.rdy_rx;
   wire        ack  = sel ? b16.ack_rx  : b32.ack_rx;
   wire        flag = sel ? b16.flag_rx : b32.flag_rx;
   wire [1:0]  err  = sel ? b16.err_rx  : b32.err_rx;
   wire [31:0] din  = sel ? {16'h0000, b16.din_rx} : b32.din_rx;
   wire [3:0]  ndg  = sel ? {1'b0, b16.ndig} : b32.ndig;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one byte and hold it until consumed; returns #1 after the consuming edge
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      d   = b;
      vld = 1'b1;
      while (rdy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (rdy !== 1'b1) begin
         bad++;
         $display("FAIL send_timeout byte=%h rdy=%b want 1", b, rdy);
         vld = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         vld = 1'b0;
      end
   endtask

   // Raise req for one IDLE sample edge, then drop it
   task automatic start_req(input logic t);
      @(negedge clk);
      req = 1'b1;
      typ = t;
      @(posedge clk);
      #1;
      req = 1'b0;
      total++;
      if (rdy !== 1'b1) begin bad++; $display("FAIL start_rdy got=%b want=1", rdy); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      total++; if (rdy  !== 1'b0)  begin bad++; $display("FAIL rst_rdy got=%b want=0", rdy); end
      total++; if (ack  !== 1'b0)  begin bad++; $display("FAIL rst_ack got=%b want=0", ack); end
      total++; if (flag !== 1'b0)  begin bad++; $display("FAIL rst_flag got=%b want=0", flag); end
      total++; if (err  !== 2'd0)  begin bad++; $display("FAIL rst_err got=%0d want=0", err); end
      total++; if (din  !== 32'h0) begin bad++; $display("FAIL rst_din got=%h want=0", din); end
      total++; if (ndg  !== 4'd0)  begin bad++; $display("FAIL rst_ndig got=%0d want=0", ndg); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL idle_rdy got=%b want=0", rdy); end
   endtask

   task automatic test_byte();
      sel = 1'b0;
      start_req(1'b0);
      send_byte(8'h41);
      total++; if (ack  !== 1'b1)         begin bad++; $display("FAIL byte_ack got=%b want=1", ack); end
      total++; if (din  !== 32'h00000041) begin bad++; $display("FAIL byte_din got=%h want=00000041", din); end
      total++; if (flag !== 1'b0)         begin bad++; $display("FAIL byte_flag got=%b want=0", flag); end
      total++; if (err  !== 2'd0)         begin bad++; $display("FAIL byte_err got=%0d want=0", err); end
      total++; if (ndg  !== 4'd0)         begin bad++; $display("FAIL byte_ndig got=%0d want=0", ndg); end
      total++; if (rdy  !== 1'b0)         begin bad++; $display("FAIL byte_done_rdy got=%b want=0", rdy); end
      @(posedge clk); #1;
      total++; if (ack  !== 1'b0)         begin bad++; $display("FAIL byte_ack_pulse got=%b want=0", ack); end
      total++; if (rdy  !== 1'b0)         begin bad++; $display("FAIL byte_idle_rdy got=%b want=0", rdy); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (din  !== 32'h00000041) begin bad++; $display("FAIL byte_hold got=%h want=00000041", din); end
   endtask

   task automatic test_hex();
      logic [7:0] s [6];
      s = '{8'h20, 8'h31, 8'h61, 8'h42, 8'h33, 8'h0D};
      sel = 1'b0;
      start_req(1'b1);
      for (int i = 0; i < 5; i++) begin
         send_byte(s[i]);
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL hex_early_ack idx=%0d got=%b want=0", i, ack); end
      end
      send_byte(s[5]);
      total++; if (ack  !== 1'b1)         begin bad++; $display("FAIL hex_ack got=%b want=1", ack); end
      total++; if (din  !== 32'h00001AB3) begin bad++; $display("FAIL hex_din got=%h want=00001ab3", din); end
      total++; if (ndg  !== 4'd4)         begin bad++; $display("FAIL hex_ndig got=%0d want=4", ndg); end
      total++; if (flag !== 1'b0)         begin bad++; $display("FAIL hex_flag got=%b want=0", flag); end
      total++; if (err  !== 2'd0)         begin bad++; $display("FAIL hex_err got=%0d want=0", err); end
      @(posedge clk); #1;
      total++; if (ack  !== 1'b0)         begin bad++; $display("FAIL hex_ack_pulse got=%b want=1 cycle", ack); end
   endtask

   task automatic test_empty();
      sel = 1'b0;
      start_req(1'b1);
      send_byte(8'h0D);
      total++; if (ack  !== 1'b1)  begin bad++; $display("FAIL empty_ack got=%b want=1", ack); end
      total++; if (err  !== 2'd1)  begin bad++; $display("FAIL empty_err got=%0d want=1", err); end
      total++; if (flag !== 1'b1)  begin bad++; $display("FAIL empty_flag got=%b want=1", flag); end
      total++; if (din  !== 32'h0) begin bad++; $display("FAIL empty_din got=%h want=0", din); end
      // LF presented while DONE/IDLE must not be consumed
      @(negedge clk);
      d   = 8'h0A;
      vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++; if (rdy !== 1'b0) begin bad++; $display("FAIL empty_lf_rdy cyc=%0d got=%b want=0", i, rdy); end
         @(negedge clk);
      end
      vld = 1'b0;
   endtask

   task automatic test_overflow();
      logic [7:0] s [6];
      s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0A};
      sel = 1'b1;
      start_req(1'b1);
      for (int i = 0; i < 5; i++) begin
         send_byte(s[i]);
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL ovf_early_ack idx=%0d got=%b want=0", i, ack); end
      end
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ovf_drain_rdy got=%b want=1", rdy); end
      send_byte(s[5]);
      total++; if (ack  !== 1'b1)    begin bad++; $display("FAIL ovf_ack got=%b want=1", ack); end
      total++; if (err  !== 2'd3)    begin bad++; $display("FAIL ovf_err got=%0d want=3", err); end
      total++; if (flag !== 1'b1)    begin bad++; $display("FAIL ovf_flag got=%b want=1", flag); end
      total++; if (din  !== 32'h1234) begin bad++; $display("FAIL ovf_din got=%h want=1234", din); end
      total++; if (ndg  !== 4'd4)    begin bad++; $display("FAIL ovf_ndig got=%0d want=4", ndg); end
      @(posedge clk); #1;
      sel = 1'b0;
   endtask

   task automatic test_badch();
      logic [7:0] s [8];
      s = '{8'h31, 8'h32, 8'h47, 8'h34, 8'h20, 8'h7A, 8'h7A, 8'h0A};
      sel = 1'b0;
      start_req(1'b1);
      for (int i = 0; i < 7; i++) begin
         send_byte(s[i]);
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL bad_early_ack idx=%0d got=%b want=0", i, ack); end
      end
      send_byte(s[7]);
      total++; if (ack  !== 1'b1) begin bad++; $display("FAIL bad_ack got=%b want=1", ack); end
      total++; if (err  !== 2'd2) begin bad++; $display("FAIL bad_err got=%0d want=2", err); end
      total++; if (flag !== 1'b1) begin bad++; $display("FAIL bad_flag got=%b want=1", flag); end
      @(posedge clk); #1;
      total++; if (ack  !== 1'b0) begin bad++; $display("FAIL bad_ack_once got=%b want=0", ack); end
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      start_req(1'b1);
      send_byte(8'h41);
      send_byte(8'h42);
      #2;
      rst = 1'b1;
      #1;
      total++; if (din  !== 32'h0) begin bad++; $display("FAIL mid_rst_din got=%h want=0", din); end
      total++; if (ndg  !== 4'd0)  begin bad++; $display("FAIL mid_rst_ndig got=%0d want=0", ndg); end
      total++; if (rdy  !== 1'b0)  begin bad++; $display("FAIL mid_rst_rdy got=%b want=0", rdy); end
      total++; if (err  !== 2'd0)  begin bad++; $display("FAIL mid_rst_err got=%0d want=0", err); end
      @(negedge clk);
      rst = 1'b0;
      start_req(1'b1);
      send_byte(8'h37);
      send_byte(8'h20);
      total++; if (ack  !== 1'b1)  begin bad++; $display("FAIL post_rst_ack got=%b want=1", ack); end
      total++; if (din  !== 32'h7) begin bad++; $display("FAIL post_rst_din got=%h want=00000007", din); end
      total++; if (ndg  !== 4'd1)  begin bad++; $display("FAIL post_rst_ndig got=%0d want=1", ndg); end
      total++; if (err  !== 2'd0)  begin bad++; $display("FAIL post_rst_err got=%0d want=0", err); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      d     = 8'h00;
      vld   = 1'b0;
      req   = 1'b0;
      typ   = 1'b0;
      sel   = 1'b0;
      test_reset();
      test_byte();
      test_hex();
      test_empty();
      test_overflow();
      test_badch();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
